// File: rtl/calc_key_entry_if.sv
// rtl/calc_key_entry_if.sv - key event input and operand valid/ready handshake bundle
interface calc_key_entry_if #(
    parameter int NUM_DIGITS = 2
) ();
    logic [8:0]              key_code;
    logic                    key_valid;
    logic                    out_valid;
    logic                    out_ready;
    logic [4*NUM_DIGITS-1:0] operand_a;
    logic [4*NUM_DIGITS-1:0] operand_b;
    logic [1:0]              op;

    modport slave (
        input  key_code, key_valid, out_ready,
        output out_valid, operand_a, operand_b, op
    );

    modport master (
        output key_code, key_valid, out_ready,
        input  out_valid, operand_a, operand_b, op
    );
endinterface

// File: rtl/calc_key_entry.sv
// rtl/calc_key_entry.sv - FSM-sequenced keypad entry of two BCD operands and an operator
module calc_key_entry #(
    parameter int NUM_DIGITS = 2,
    parameter bit MUL_EN     = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    calc_key_entry_if.slave         bus,
    output logic [4*NUM_DIGITS-1:0] disp_bcd,
    output logic [3:0]              digit_cnt,
    output logic [1:0]              state
);
    localparam int W = 4 * NUM_DIGITS;

    typedef enum logic [1:0] {
        ENTRY_A  = 2'b00,
        ENTRY_B  = 2'b01,
        WAIT_ACK = 2'b10
    } state_t;

    state_t         state_q;
    logic [W-1:0]   operand_a_q;
    logic [W-1:0]   operand_b_q;
    logic [1:0]     op_q;
    logic           out_valid_q;

    logic           is_digit;
    logic [3:0]     digit_val;
    logic           is_enter;
    logic           is_op;
    logic [1:0]     op_code;
    logic           room;
    logic [W-1:0]   a_shifted;
    logic [W-1:0]   b_shifted;

    always_comb begin
        is_digit  = 1'b0;
        digit_val = 4'd0;
        is_enter  = 1'b0;
        is_op     = 1'b0;
        op_code   = 2'b00;
        case (bus.key_code)
            9'h070: begin is_digit = 1'b1; digit_val = 4'd0; end
            9'h069: begin is_digit = 1'b1; digit_val = 4'd1; end
            9'h072: begin is_digit = 1'b1; digit_val = 4'd2; end
            9'h07A: begin is_digit = 1'b1; digit_val = 4'd3; end
            9'h06B: begin is_digit = 1'b1; digit_val = 4'd4; end
            9'h073: begin is_digit = 1'b1; digit_val = 4'd5; end
            9'h074: begin is_digit = 1'b1; digit_val = 4'd6; end
            9'h06C: begin is_digit = 1'b1; digit_val = 4'd7; end
            9'h075: begin is_digit = 1'b1; digit_val = 4'd8; end
            9'h07D: begin is_digit = 1'b1; digit_val = 4'd9; end
            9'h05A, 9'h15A: is_enter = 1'b1;
            9'h01C: begin is_op = 1'b1; op_code = 2'b00; end
            9'h01B: begin is_op = 1'b1; op_code = 2'b01; end
            9'h03A: begin is_op = MUL_EN; op_code = 2'b10; end
            default: ;
        endcase
    end

    // A full operand drops further digits rather than shifting its top digit out.
    assign room      = (digit_cnt < 4'(NUM_DIGITS));
    assign a_shifted = W'({operand_a_q, digit_val});
    assign b_shifted = W'({operand_b_q, digit_val});

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ENTRY_A;
            operand_a_q <= '0;
            operand_b_q <= '0;
            op_q        <= 2'b00;
            out_valid_q <= 1'b0;
            digit_cnt   <= 4'd0;
            disp_bcd    <= '0;
        end else begin
            case (state_q)
                ENTRY_A: begin
                    if (bus.key_valid) begin
                        if (is_digit && room) begin
                            operand_a_q <= a_shifted;
                            disp_bcd    <= a_shifted;
                            digit_cnt   <= digit_cnt + 4'd1;
                        end else if (is_op) begin
                            op_q        <= op_code;
                            state_q     <= ENTRY_B;
                            operand_b_q <= '0;
                            disp_bcd    <= '0;
                            digit_cnt   <= 4'd0;
                        end
                    end
                end
                ENTRY_B: begin
                    if (bus.key_valid) begin
                        if (is_digit && room) begin
                            operand_b_q <= b_shifted;
                            disp_bcd    <= b_shifted;
                            digit_cnt   <= digit_cnt + 4'd1;
                        end else if (is_op && digit_cnt == 4'd0) begin
                            op_q <= op_code;
                        end else if (is_enter && digit_cnt != 4'd0) begin
                            state_q     <= WAIT_ACK;
                            out_valid_q <= 1'b1;
                        end
                    end
                end
                WAIT_ACK: begin
                    // Keys are dropped here, including one coinciding with the handshake.
                    if (bus.out_ready) begin
                        state_q     <= ENTRY_A;
                        operand_a_q <= '0;
                        operand_b_q <= '0;
                        op_q        <= 2'b00;
                        out_valid_q <= 1'b0;
                        digit_cnt   <= 4'd0;
                        disp_bcd    <= '0;
                    end
                end
                default: begin
                    state_q     <= ENTRY_A;
                    operand_a_q <= '0;
                    operand_b_q <= '0;
                    op_q        <= 2'b00;
                    out_valid_q <= 1'b0;
                    digit_cnt   <= 4'd0;
                    disp_bcd    <= '0;
                end
            endcase
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.operand_a = operand_a_q;
    assign bus.operand_b = operand_b_q;
    assign bus.op        = op_q;
    assign state         = state_q;
endmodule

// File: doc/calc_key_entry.md
Name: calc_key_entry

Overview:
- Sequential key-entry controller for the keypad calculator datapath.
- Consumes one-cycle PS/2 key events (9-bit code, bit 8 = E0 extend flag) and decodes them internally to digit, operator and Enter keys.
- Assembles two multi-digit BCD operands and an operator, then presents them to the arithmetic unit through a valid/ready handshake.
- Generalises the combinational scan-code decoder: operand width is parametrised, there is an optional multiply mode, and entry is FSM-sequenced.

Parameters:
- NUM_DIGITS, 2, BCD digits per operand; legal range 1..8.
- MUL_EN, 1, 1 = M key accepted; 0 = M key ignored.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- key_code  in  9  scan code of the pressed key; valid only when key_valid=1.
- key_valid  in  1  one-cycle pulse per make event; every high cycle is a separate event.
- out_valid  out  1  operand_a, operand_b and op are complete and held stable.
- out_ready  in  1  consumer accepts the operands; transfer occurs when out_valid and out_ready are both 1.
- operand_a  out  4*NUM_DIGITS  first operand, BCD, most significant digit at the top.
- operand_b  out  4*NUM_DIGITS  second operand, BCD.
- op  out  2  operator: 00 add, 01 sub, 10 mul.
- disp_bcd  out  4*NUM_DIGITS  operand currently being entered, for the 7-segment display.
- digit_cnt  out  4  digits entered in the current operand.
- state  out  2  00 ENTRY_A, 01 ENTRY_B, 10 WAIT_ACK.

Behaviour:
- Decode is on the full 9-bit code:
  - 070 = 0, 069 = 1, 072 = 2, 07A = 3, 06B = 4, 073 = 5, 074 = 6, 06C = 7, 075 = 8, 07D = 9.
  - 05A and 15A = Enter.
  - 01C = A (add), 01B = S (sub), 03A = M (mul).
  - Any other code is ignored, with no state change.
- Reset: state ENTRY_A; operand_a, operand_b, op, digit_cnt and out_valid all 0. disp_bcd is therefore 0.
- Every key event takes effect on the clock edge where key_valid=1. Outputs update the following cycle, with no further latency.
- Digit key d in ENTRY_A or ENTRY_B:
  - If digit_cnt < NUM_DIGITS, the current operand becomes (operand shifted left by one digit, d in the low nibble), and digit_cnt increments.
  - If digit_cnt == NUM_DIGITS, the digit is dropped. The operand does not wrap or shift out.
  - Leading 0 digits are counted as digits.
- Operator key in ENTRY_A: op latched, state goes to ENTRY_B, digit_cnt cleared, operand_b cleared. With digit_cnt = 0, operand_a = 0 is valid.
- Operator key in ENTRY_B:
  - digit_cnt == 0: op is replaced.
  - digit_cnt > 0: ignored.
- M key with MUL_EN=0: ignored in every state.
- Enter in ENTRY_A: ignored.
- Enter in ENTRY_B:
  - digit_cnt == 0: ignored.
  - digit_cnt > 0: state goes to WAIT_ACK and out_valid=1 from the next cycle.
- WAIT_ACK:
  - All key events are dropped.
  - operand_a, operand_b and op are held stable while out_valid=1.
  - out_valid stays 1 until out_ready=1 is sampled.
  - On the handshake edge, the next cycle has state ENTRY_A, out_valid=0, operands, op and digit_cnt all 0.
- out_ready is ignored when out_valid=0.
- key_valid coinciding with the handshake edge: the key is dropped; the handshake takes priority.
- disp_bcd:
  - ENTRY_A: operand_a.
  - ENTRY_B: operand_b; shows 0 until the first B digit.
  - WAIT_ACK: operand_b.
- Synchronous reset mid-entry or mid-handshake discards everything; out_valid falls on the next cycle regardless of out_ready.
- All outputs are registered; no combinational path from key_code to any output.

Test Plan:
- NUM_DIGITS=2. Keys 069, 072, 01C, 07D, 05A, out_ready=0 -> operand_a=12, op=00, operand_b=09, out_valid=1, state=10 held for 10 cycles.
- Then out_ready=1 for 1 cycle with key_valid=1, key 070 -> next cycle state=00, out_valid=0, operand_a=00, digit_cnt=0; the 070 key is not captured.
- Keys 069, 072, 07A (third digit) -> operand_a=12, digit_cnt=2. Then 01B, 01C, 069, 03A -> op=00 (A replaced S before any B digit); the M after the digit is ignored, so op stays 00 and operand_b=01.
- Enter 15A in ENTRY_A -> no change. Unknown code 0E0 in any state -> no change. 01C then immediate 05A -> ignored, state stays 01.
- MUL_EN=0: 069 then 03A -> state stays 00. MUL_EN=1: same sequence -> state 01, op=10.
- Mid-WAIT_ACK with out_ready=0, assert rst for 1 cycle -> next cycle all outputs 0, state 00.
